// File: rtl/sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_port_arbiter
// Brief    : Round-robin two-port arbiter and access sequencer for a
//            4-entry x 1-bit sram. Grants one client per 3-cycle
//            IDLE/ACCESS/DONE sequence. Read data and a one-cycle ack go
//            back to the client that won.
// Revision : 1.0 - initial release
// ============================================================================
module sram_port_arbiter #(
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,        // asynchronous, active-low
  input  logic              a_req,
  input  logic              a_rw,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic              a_wdata,
  output logic              a_ack,
  input  logic              b_req,
  input  logic              b_rw,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic              b_wdata,
  output logic              b_ack,
  output logic              rdata,
  output logic              busy,
  output logic              sram_din,
  output logic              sram_rw,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic              sram_dout
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_last;    // 1 = port B was served last
  logic              r_win_b;   // 1 = current transaction belongs to port B
  logic              r_rw;      // latched direction of current transaction

  logic              w_grant_b;
  logic              w_rw;
  logic [ADDR_W-1:0] w_addr;
  logic              w_wdata;

  // Pick the winner. A lone requester wins; on a tie the port not served last wins.
  always_comb begin
    w_grant_b = 1'b0;
    if (a_req && !b_req) begin
      w_grant_b = 1'b0;
    end else if (b_req && !a_req) begin
      w_grant_b = 1'b1;
    end else begin
      w_grant_b = ~r_last;
    end
    w_rw    = w_grant_b ? b_rw    : a_rw;
    w_addr  = w_grant_b ? b_addr  : a_addr;
    w_wdata = w_grant_b ? b_wdata : a_wdata;
  end

  // Sequencer FSM. Every output is a register, so nothing glitches on client inputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_last    <= 1'b1;
      r_win_b   <= 1'b0;
      r_rw      <= 1'b0;
      a_ack     <= 1'b0;
      b_ack     <= 1'b0;
      rdata     <= 1'b0;
      busy      <= 1'b0;
      sram_rw   <= 1'b0;
      sram_addr <= '0;
      sram_din  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          a_ack <= 1'b0;
          b_ack <= 1'b0;
          if (a_req || b_req) begin
            r_state   <= S_ACCESS;
            r_last    <= w_grant_b;
            r_win_b   <= w_grant_b;
            r_rw      <= w_rw;
            sram_addr <= w_addr;
            sram_din  <= w_wdata;
            sram_rw   <= w_rw;    // write strobe lives only in ACCESS
            busy      <= 1'b1;
          end
        end
        S_ACCESS: begin
          r_state <= S_DONE;
          sram_rw <= 1'b0;
          if (!r_rw) begin
            rdata <= sram_dout;
          end
          a_ack <= ~r_win_b;
          b_ack <= r_win_b;
        end
        S_DONE: begin
          r_state <= S_IDLE;
          a_ack   <= 1'b0;
          b_ack   <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          a_ack   <= 1'b0;
          b_ack   <= 1'b0;
          busy    <= 1'b0;
          sram_rw <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_port_arbiter
// Brief    : Directed self-checking bench for sram_port_arbiter, with a
//            behavioural 4 x 1 sram attached.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_port_arbiter;

  localparam int ADDR_W = 2;

  logic              clk;
  logic              rst;
  logic              a_req, a_rw, a_wdata, a_ack;
  logic [ADDR_W-1:0] a_addr;
  logic              b_req, b_rw, b_wdata, b_ack;
  logic [ADDR_W-1:0] b_addr;
  logic              rdata, busy, sram_din, sram_rw, sram_dout;
  logic [ADDR_W-1:0] sram_addr;

  int n_checks;
  int n_fail;

  logic mem [4];

  sram_port_arbiter #(.ADDR_W(ADDR_W)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .a_req     (a_req),
    .a_rw      (a_rw),
    .a_addr    (a_addr),
    .a_wdata   (a_wdata),
    .a_ack     (a_ack),
    .b_req     (b_req),
    .b_rw      (b_rw),
    .b_addr    (b_addr),
    .b_wdata   (b_wdata),
    .b_ack     (b_ack),
    .rdata     (rdata),
    .busy      (busy),
    .sram_din  (sram_din),
    .sram_rw   (sram_rw),
    .sram_addr (sram_addr),
    .sram_dout (sram_dout)
  );

  // Behavioural sram: write on the rising edge while RW is high, combinational read.
  always @(posedge clk) begin
    if (sram_rw) mem[sram_addr] <= sram_din;
  end
  assign sram_dout = mem[sram_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_port(input bit port_b, input bit req, input bit rw,
                            input logic [ADDR_W-1:0] addr, input bit wd);
    if (port_b) begin
      b_req = req; b_rw = rw; b_addr = addr; b_wdata = wd;
    end else begin
      a_req = req; a_rw = rw; a_addr = addr; a_wdata = wd;
    end
  endtask

  // One full transaction from one port, checked cycle by cycle at falling edges.
  task automatic txn(input bit port_b, input bit rw, input logic [ADDR_W-1:0] addr,
                     input bit wd, input bit exp_rd);
    @(negedge clk);
    drive_port(port_b, 1'b1, rw, addr, wd);
    @(negedge clk);                       // ACCESS
    check("acc_busy", busy, 1);
    check("acc_rw", sram_rw, rw);
    check("acc_addr", sram_addr, addr);
    if (rw) check("acc_din", sram_din, wd);
    check("acc_noack", {a_ack, b_ack}, 2'b00);
    @(negedge clk);                       // DONE
    check("done_ack", {a_ack, b_ack}, port_b ? 2'b01 : 2'b10);
    check("done_rw", sram_rw, 0);
    check("done_addr", sram_addr, addr);
    check("done_rdata", rdata, exp_rd);
    drive_port(port_b, 1'b0, 1'b0, '0, 1'b0);
    @(negedge clk);                       // back in IDLE
    check("idle_busy", busy, 0);
    check("idle_noack", {a_ack, b_ack}, 2'b00);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 4; i++) mem[i] = 1'b0;
    rst = 1'b0;
    a_req = 0; a_rw = 0; a_addr = '0; a_wdata = 0;
    b_req = 0; b_rw = 0; b_addr = '0; b_wdata = 0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_rw", sram_rw, 0);
    check("rst_addr", sram_addr, 0);
    check("rst_din", sram_din, 0);
    check("rst_acks", {a_ack, b_ack}, 2'b00);
    check("rst_rdata", rdata, 0);
    rst = 1'b1;

    // Single write then reads
    txn(1'b0, 1'b1, 2'd2, 1'b1, 1'b0);
    check("mem2_after_wr", mem[2], 1);
    txn(1'b0, 1'b0, 2'd2, 1'b0, 1'b1);
    txn(1'b0, 1'b0, 2'd1, 1'b0, 1'b0);

    // Simultaneous requests after reset: A first, then alternate
    do_reset();
    @(negedge clk);
    drive_port(1'b0, 1'b1, 1'b0, 2'd2, 1'b0);   // A reads addr 2 -> 1
    drive_port(1'b1, 1'b1, 1'b0, 2'd0, 1'b0);   // B reads addr 0 -> 0
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      check("tie_a_ack", a_ack, (i == 2 || i == 8) ? 1 : 0);
      check("tie_b_ack", b_ack, (i == 5 || i == 11) ? 1 : 0);
      check("tie_not_both", a_ack & b_ack, 0);
      if (i == 2 || i == 8)  check("tie_a_rdata", rdata, 1);
      if (i == 5 || i == 11) check("tie_b_rdata", rdata, 0);
      if (i == 11) begin
        drive_port(1'b0, 1'b0, 1'b0, '0, 1'b0);
        drive_port(1'b1, 1'b0, 1'b0, '0, 1'b0);
      end
    end

    // Port B alone after reset: write 1 everywhere, read back
    do_reset();
    for (int i = 0; i < 4; i++) txn(1'b1, 1'b1, 2'(i), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) txn(1'b1, 1'b0, 2'(i), 1'b0, 1'b1);

    // Field change after grant: clear addr 3, then write 1 while fields flip
    txn(1'b0, 1'b1, 2'd3, 1'b0, 1'b1);
    check("mem3_cleared", mem[3], 0);
    @(negedge clk);
    drive_port(1'b0, 1'b1, 1'b1, 2'd3, 1'b1);
    @(negedge clk);                       // ACCESS
    check("fc_addr", sram_addr, 3);
    a_addr = 2'd0;
    a_wdata = 1'b0;
    @(negedge clk);                       // DONE
    check("fc_ack", a_ack, 1);
    drive_port(1'b0, 1'b0, 1'b0, '0, 1'b0);
    @(negedge clk);
    check("fc_mem3", mem[3], 1);
    check("fc_mem0", mem[0], 1);

    // Reset mid-ACCESS: clear addr 1, then abort a write of 1 to it
    txn(1'b0, 1'b1, 2'd1, 1'b0, 1'b1);
    check("mem1_cleared", mem[1], 0);
    @(negedge clk);
    drive_port(1'b0, 1'b1, 1'b1, 2'd1, 1'b1);
    @(posedge clk);
    #1;
    check("ma_rw_before", sram_rw, 1);
    #1 rst = 1'b0;
    #1;
    check("ma_rw_async", sram_rw, 0);
    check("ma_busy_async", busy, 0);
    drive_port(1'b0, 1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("ma_rst_rw", sram_rw, 0);
      check("ma_rst_ack", {a_ack, b_ack}, 2'b00);
    end
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("ma_post_busy", busy, 0);
      check("ma_post_ack", {a_ack, b_ack}, 2'b00);
    end
    check("ma_mem1", mem[1], 0);
    txn(1'b0, 1'b0, 2'd1, 1'b0, 1'b0);

    // Idle behaviour: load rdata=1 then stay quiet for 10 cycles
    txn(1'b1, 1'b0, 2'd3, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_busy10", busy, 0);
      check("idle_rw10", sram_rw, 0);
      check("idle_acks10", {a_ack, b_ack}, 2'b00);
      check("idle_rdata10", rdata, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Two-requester arbiter and access sequencer for the 4-entry × 1-bit `sram` block. It accepts single-bit read/write requests from two independent clients (port A, port B) and grants them round-robin. It drives the sram's `DataIn`/`RW`/`Address` inputs through a 3-state FSM, and returns read data plus a one-cycle acknowledge to the winning client. It sits between the client logic and the `sram` instance; clients never drive the sram directly.

## Interface
- `ADDR_W`, default 2: address width; must match the sram `Address` width.
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-low (`rst`=0 resets).
- `a_req` in 1: port A request; level, held until `a_ack`.
- `a_rw` in 1: port A direction, 1 = write, 0 = read.
- `a_addr` in ADDR_W: port A address.
- `a_wdata` in 1: port A write data.
- `a_ack` out 1: one-cycle pulse; port A transaction complete.
- `b_req`, `b_rw`, `b_addr`, `b_wdata`, `b_ack`: same as port A, for port B.
- `rdata` out 1: read result of the most recently acknowledged read; held until the next read completes.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `sram_din` out 1: to sram `DataIn`.
- `sram_rw` out 1: to sram `RW`; 1 = write cycle.
- `sram_addr` out ADDR_W: to sram `Address`.
- `sram_dout` in 1: from sram `DataOut`; combinational read of the addressed cell.

## Operation
- **FSM states:** IDLE, ACCESS, DONE.
  - IDLE → ACCESS when `a_req` or `b_req` is high at the clock edge. Otherwise stay in IDLE.
  - ACCESS → DONE unconditionally.
  - DONE → IDLE unconditionally.
- **Arbitration (at the IDLE edge only):**
  - Only one port requesting: that port wins.
  - Both requesting: the port not served last wins.
  - `last` pointer resets to B, so A wins the first tie.
  - `last` updates to the winner on the grant edge.
- **Capture:** on the grant edge, the winner's `rw`, `addr` and `wdata` are latched into internal registers. Later changes on client inputs are ignored until the next grant.
- **ACCESS:**
  - `sram_addr` = latched addr and `sram_din` = latched wdata.
  - `sram_rw` = latched rw, asserted for exactly this one cycle. A write therefore lands in the sram cell on the ACCESS→DONE edge.
  - For a read, `rdata` loads from `sram_dout` on the ACCESS→DONE edge.
- **DONE:**
  - The winner's ack is high for this cycle only.
  - `sram_rw` = 0 and `sram_addr` holds the latched value.
- **Outside ACCESS:** `sram_rw` = 0 always, so no stray writes occur. `sram_addr` and `sram_din` hold their last latched values.
- **Request handshake:** a client deasserts req in the cycle after seeing ack. If req is still high in the following IDLE cycle, it is treated as a new request with the currently presented fields (back-to-back allowed).
- **Write acks:** a write ack does not change `rdata`.

## Timing
- **Reset values** (asynchronous, while `rst`=0): state = IDLE, `last` = B, `a_ack` = `b_ack` = 0, `rdata` = 0, `busy` = 0, `sram_rw` = 0, `sram_addr` = 0, `sram_din` = 0.
- **Latency:** req sampled high at edge k; ACCESS during cycle k..k+1; ack high during cycle k+1..k+2. Request-to-ack is 2 cycles.
- **Throughput:** one transaction per 3 cycles. With both ports held high, service alternates A, B, A, B…
- **Request in the ack cycle:** a request arriving during ACCESS or DONE waits; it is sampled at the next IDLE edge.
- **Reset mid-ACCESS:** `sram_rw` drops to 0 asynchronously, so no write occurs. No ack is issued, the FSM returns to IDLE, and the transaction is lost. The client re-requests after reset.
- **Reset mid-DONE:** the ack is cut short and `rdata` returns to 0.
- **Address/data rules:** `sram_addr` is a full-range ADDR_W value with no bounds check. All 2^ADDR_W addresses are legal.
- **Glitch-free outputs:** all outputs are registered or decoded from registered state only. No combinational path from client inputs to sram outputs or acks.

## Test plan
- **Single write then read:** reset, then A writes addr 2, data 1 (`a_rw`=1). Required: `sram_rw`=1 for exactly one cycle with `sram_addr`=2; `a_ack` pulses 2 cycles after req. Then A reads addr 2: `rdata`=1 at the `a_ack` cycle; reading addr 1 gives `rdata`=0.
- **Simultaneous requests:** A and B raise req in the same cycle and both hold it for 4 transactions. Required: ack order A, B, A, B, one ack every 3 cycles, never both acks high in the same cycle.
- **Port B alone after reset:** B writes 1 to addrs 0–3, then reads all four. Required: `rdata`=1 each time, `a_ack` never asserted, `busy` high 2 of every 3 cycles.
- **Field change after grant:** A requests a write of addr 3, data 1, then flips `a_addr` to 0 and `a_wdata` to 0 during ACCESS. Required: the sram cell at addr 3 = 1 and the cell at addr 0 is unchanged.
- **Reset mid-ACCESS:** a write of 1 to addr 1 is pulled to `rst`=0 during ACCESS and released two cycles later. Required: no ack, FSM in IDLE, `sram_rw`=0 during reset, and a later read of addr 1 returns 0.
- **Idle behaviour:** no requests for 10 cycles. Required: `busy`=0, `sram_rw`=0, no acks, `rdata` unchanged.
